// File: rtl/regfile_dump_pkg.sv
// Shared register-file widths and the dump sequencer state encoding.
package regfile_dump_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Debug read-out sequencer: walks a register range through one read port
// and streams (index, value) beats on a valid/ready interface.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int LAST_MAX = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [REG_AW-1:0] first,
  input  logic [REG_AW-1:0] last,
  output logic [REG_AW-1:0] rf_ra,
  input  logic [XLEN-1:0]   rf_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [REG_AW-1:0] m_addr,
  output logic [XLEN-1:0]   m_data,
  output logic              busy,
  output logic              done
);

  localparam logic [REG_AW-1:0] LAST_CAP = REG_AW'(LAST_MAX);

  dump_state_t       state_reg, state_next;
  logic [REG_AW-1:0] ptr_reg, ptr_next;
  logic [REG_AW-1:0] end_reg, end_next;
  logic [REG_AW-1:0] addr_reg, addr_next;
  logic [XLEN-1:0]   data_reg, data_next;
  logic [REG_AW-1:0] end_clamped;

  assign end_clamped = (last > LAST_CAP) ? LAST_CAP : last;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    end_next   = end_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          ptr_next   = first;
          end_next   = end_clamped;
          state_next = (first <= end_clamped) ? READ : FIN;
        end
      end
      READ: begin
        // Snapshot the beat so later pipeline writes cannot disturb it.
        addr_next  = ptr_reg;
        data_next  = rf_rd;
        state_next = SEND;
      end
      SEND: begin
        if (m_ready) begin
          if (ptr_reg == end_reg) begin
            state_next = FIN;
          end else begin
            ptr_next   = ptr_reg + 1'b1;
            state_next = READ;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      end_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      end_reg   <= end_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  assign rf_ra   = (state_reg == READ) ? ptr_reg : '0;
  assign m_valid = (state_reg == SEND);
  assign m_addr  = addr_reg;
  assign m_data  = data_reg;
  assign busy    = (state_reg != IDLE);
  // An abort arriving in FIN also suppresses the completion pulse.
  assign done    = (state_reg == FIN) && !abort;

endmodule
